// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_pkg
// Purpose : Shared types and constants for the seven-segment scan controller:
//           scan state encoding, active-low segment patterns for hex digits,
//           and the "all dark" segment / enable values.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package seven_segment_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] EN_OFF  = 4'b1111;

    // Active-low {dp,g,f,e,d,c,b,a}; dp bit is stored as 1 and replaced on use.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Full active-low segment byte for a nibble and its decimal point.
    function automatic logic [7:0] seg_decode(input logic [3:0] nibble,
                                              input logic       dp);
        logic [7:0] pattern;
        pattern = SEG_TABLE[nibble];
        return {~dp, pattern[6:0]};
    endfunction

endpackage : seven_segment_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Purpose : Two-flop synchronizer, counter-based debouncer and rising-edge
//           pulse generator for one raw push button.
// Ports   : clk          - system clock
//           rst          - asynchronous active-high reset
//           button_raw   - raw asynchronous button level
//           rise_pulse   - one-cycle pulse when the debounced level rises
// Rev     : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic rise_pulse
);

    localparam int            CW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_level    <= 1'b0;
            r_count    <= '0;
            rise_pulse <= 1'b0;
        end else begin
            r_sync1    <= button_raw;
            r_sync2    <= r_sync1;
            rise_pulse <= 1'b0;
            if (r_sync2 != r_level) begin
                // The synced level must differ for DEBOUNCE_CYCLES consecutive
                // clocks; any return to the accepted level restarts the count.
                if (r_count == C_LAST) begin
                    r_level    <= r_sync2;
                    r_count    <= '0;
                    rise_pulse <= r_sync2;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else begin
                r_count <= '0;
            end
        end
    end

endmodule : button_debouncer
`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_scan_controller
// Purpose : Time-multiplexes a 4-digit common-anode seven-segment display.
//           Alternates BLANK / SHOW slots per digit, decodes hex nibbles,
//           and keeps a per-digit enable mask toggled by debounced buttons.
// Ports   : clockIn            - system clock
//           resetIn            - asynchronous active-high reset
//           digitValues[15:0]  - digit i = bits [4i+3:4i]
//           decimalPoints[3:0] - DP request per digit
//           controlButtons[3:0]- raw buttons, bit i toggles digit i enable
//           sevenSegmentData   - active-low {dp,g,f,e,d,c,b,a}
//           sevenSegmentEnable - active-low anode enables
//           digitMask          - per-digit enable state, 1 = shown
//           frameStart         - pulse on entry to SHOW for digit 0
// Rev     : 1.0  initial release
// ============================================================================
module seven_segment_scan_controller
    import seven_segment_pkg::*;
#(
    parameter int SHOW_CYCLES     = 100000,
    parameter int BLANK_CYCLES    = 1000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic [15:0] digitValues,
    input  logic [3:0]  decimalPoints,
    input  logic [3:0]  controlButtons,
    output logic [7:0]  sevenSegmentData,
    output logic [3:0]  sevenSegmentEnable,
    output logic [3:0]  digitMask,
    output logic        frameStart
);

    localparam int            MAX_SLOT   = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int            CW         = $clog2(MAX_SLOT);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    scan_state_t   r_state;
    scan_state_t   w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;
    logic [1:0]    r_index;
    logic [1:0]    w_index_next;
    logic [3:0]    w_en_next;
    logic [7:0]    w_data_next;
    logic          w_frame_next;
    logic [3:0]    w_nibble;
    logic [3:0]    w_rise;

    // ------------------------------------------------------------------
    // Button conditioning and mask register
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_button
            button_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk        (clockIn),
                .rst        (resetIn),
                .button_raw (controlButtons[gi]),
                .rise_pulse (w_rise[gi])
            );
        end
    endgenerate

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            digitMask <= 4'b1111;
        end else begin
            digitMask <= digitMask ^ w_rise;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: state, slot counter, index and all display outputs are
    // registered together so outputs change on the state-entry edge.
    // ------------------------------------------------------------------
    assign w_nibble = 4'(digitValues >> {r_index, 2'b00});

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            r_state            <= ST_BLANK;
            r_count            <= '0;
            r_index            <= 2'd0;
            sevenSegmentEnable <= EN_OFF;
            sevenSegmentData   <= SEG_OFF;
            frameStart         <= 1'b0;
        end else begin
            r_state            <= w_state_next;
            r_count            <= w_count_next;
            r_index            <= w_index_next;
            sevenSegmentEnable <= w_en_next;
            sevenSegmentData   <= w_data_next;
            frameStart         <= w_frame_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count + CW'(1);
        w_index_next = r_index;
        w_en_next    = sevenSegmentEnable;
        w_data_next  = sevenSegmentData;
        w_frame_next = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_count == BLANK_LAST) begin
                    w_state_next = ST_SHOW;
                    w_count_next = '0;
                    // Inputs and mask are captured here and held for the slot;
                    // a masked digit keeps its slot timing but stays dark.
                    w_en_next    = digitMask[r_index] ? ~(4'b0001 << r_index) : EN_OFF;
                    w_data_next  = seg_decode(w_nibble, decimalPoints[r_index]);
                    w_frame_next = (r_index == 2'd0);
                end
            end
            ST_SHOW: begin
                if (r_count == SHOW_LAST) begin
                    w_state_next = ST_BLANK;
                    w_count_next = '0;
                    w_index_next = r_index + 2'd1;
                    w_en_next    = EN_OFF;
                    w_data_next  = SEG_OFF;
                end
            end
            default: begin
                w_state_next = ST_BLANK;
                w_count_next = '0;
                w_en_next    = EN_OFF;
                w_data_next  = SEG_OFF;
            end
        endcase
    end

endmodule : seven_segment_scan_controller
`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_scan_controller
// Purpose : Directed self-checking bench for seven_segment_scan_controller
//           with SHOW=4, BLANK=2, DEBOUNCE=3. Expected display samples are
//           queued per clock and compared as the DUT scans.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_seven_segment_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digit_values;
    logic [3:0]  decimal_points;
    logic [3:0]  buttons;
    logic [7:0]  seg_data;
    logic [3:0]  seg_en;
    logic [3:0]  mask;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] data;
        logic       fs;
    } exp_t;

    exp_t sb[$];

    seven_segment_scan_controller #(
        .SHOW_CYCLES     (4),
        .BLANK_CYCLES    (2),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clockIn            (clk),
        .resetIn            (rst),
        .digitValues        (digit_values),
        .decimalPoints      (decimal_points),
        .controlButtons     (buttons),
        .sevenSegmentData   (seg_data),
        .sevenSegmentEnable (seg_en),
        .digitMask          (mask),
        .frameStart         (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;
            4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;
            4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;
            4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;
            4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        e.en   = 4'hF;
        e.data = 8'hFF;
        e.fs   = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic push_frame(input logic [15:0] vals, input logic [3:0] dps,
                              input logic [3:0] msk);
        exp_t       e;
        logic [3:0] one;
        logic [7:0] s;
        logic [3:0] nib;
        one = 4'b0001;
        for (int d = 0; d < 4; d++) begin
            nib    = vals[4*d +: 4];
            s      = exp_seg(nib);
            e.en   = msk[d] ? ~(one << d) : 4'hF;
            e.data = {~dps[d], s[6:0]};
            for (int c = 0; c < 4; c++) begin
                e.fs = (d == 0) && (c == 0);
                sb.push_back(e);
            end
            push_dark(2);
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        tick();
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_en"},   32'(seg_en),      32'(e.en));
            chk({tag, "_data"}, 32'(seg_data),    32'(e.data));
            chk({tag, "_fs"},   32'(frame_start), 32'(e.fs));
        end
    endtask

    initial begin
        rst            = 1'b1;
        digit_values   = 16'h1234;
        decimal_points = 4'b0000;
        buttons        = 4'b0000;

        // Reset state
        repeat (3) tick();
        chk("rst_en",   32'(seg_en),      32'hF);
        chk("rst_data", 32'(seg_data),    32'hFF);
        chk("rst_mask", 32'(mask),        32'hF);
        chk("rst_fs",   32'(frame_start), 32'h0);

        // Scan order, slot timing and frameStart period over two frames
        rst = 1'b0;
        push_dark(1);
        push_frame(16'h1234, 4'b0000, 4'hF);
        push_frame(16'h1234, 4'b0000, 4'hF);
        repeat (49) step("scan");

        // Decode of every nibble on digit 0 with its DP lit
        for (int n = 0; n < 16; n++) begin
            digit_values   = {12'h123, 4'(n)};
            decimal_points = 4'b0001;
            push_frame(digit_values, decimal_points, 4'hF);
            repeat (24) step("decode");
        end

        // Mid-slot input change is held off until the next slot
        digit_values   = 16'h1234;
        decimal_points = 4'b0000;
        push_frame(16'hFFF4, 4'b0000, 4'hF);
        step("midslot");
        step("midslot");
        digit_values = 16'hFFFF;
        repeat (22) step("midslot");

        // Button 2 held 20 clocks: one toggle at k+5, digit 2 dark, timing kept
        buttons = 4'b0100;
        push_frame(16'hFFFF, 4'b0000, 4'b1011);
        for (int i = 1; i <= 24; i++) begin
            step("btn_press");
            chk("btn_press_mask", 32'(mask), (i < 6) ? 32'hF : 32'hB);
            if (i == 20) buttons = 4'b0000;
        end
        push_frame(16'hFFFF, 4'b0000, 4'b1011);
        for (int i = 1; i <= 24; i++) begin
            step("btn_held");
            chk("btn_held_mask", 32'(mask), 32'hB);
        end
        buttons = 4'b0100;
        push_frame(16'hFFFF, 4'b0000, 4'hF);
        for (int i = 1; i <= 24; i++) begin
            step("btn_restore");
            chk("btn_restore_mask", 32'(mask), (i < 6) ? 32'hB : 32'hF);
            if (i == 10) buttons = 4'b0000;
        end

        // Bouncing button 0 never settles long enough to toggle
        buttons = 4'b0001;
        push_frame(16'hFFFF, 4'b0000, 4'hF);
        for (int i = 1; i <= 24; i++) begin
            step("bounce");
            chk("bounce_mask", 32'(mask), 32'hF);
            if (i < 10 && (i % 2) == 0) buttons[0] = ~buttons[0];
            if (i == 10) buttons = 4'b0000;
        end

        // Async reset in the middle of digit 1's slot
        buttons = 4'b1000;
        push_frame(16'hFFFF, 4'b0000, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            step("rstmid");
            chk("rstmid_mask", 32'(mask), (i < 6) ? 32'hF : 32'h7);
        end
        sb.delete();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_en",   32'(seg_en),      32'hF);
        chk("async_rst_data", 32'(seg_data),    32'hFF);
        chk("async_rst_mask", 32'(mask),        32'hF);
        chk("async_rst_fs",   32'(frame_start), 32'h0);
        buttons      = 4'b0000;
        digit_values = 16'h1234;
        tick();
        tick();
        rst = 1'b0;
        push_dark(1);
        push_frame(16'h1234, 4'b0000, 4'hF);
        repeat (25) step("rst_rescan");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seven_segment_scan_controller
`default_nettype wire
